// File: rtl/lcmv_frame_sequencer.sv
// Per-frame sequencer for the T/C-load + weighting-matrix datapath: opens one AXI-stream
// path at a time (TC load, pixels, W readout), counts beats, and reports done/error.
module lcmv_frame_sequencer #(
   parameter int WIDTH           = 32,
   parameter int TC_NUM_ELEMENTS = 2544,
   parameter int P_NUM_ELEMENTS  = 692224,
   parameter int W_NUM_ELEMENTS  = 507,
   parameter int CNT_WIDTH       = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             error,
   output logic [2:0]       phase,
   output logic [15:0]      frame_count,
   input  logic [WIDTH-1:0] s_tc_data,
   input  logic             s_tc_valid,
   input  logic             s_tc_last,
   output logic             s_tc_ready,
   output logic [WIDTH-1:0] m_tc_data,
   output logic             m_tc_valid,
   output logic             m_tc_last,
   input  logic             m_tc_ready,
   input  logic [WIDTH-1:0] s_p_data,
   input  logic             s_p_valid,
   output logic             s_p_ready,
   output logic [WIDTH-1:0] m_p_data,
   output logic             m_p_valid,
   input  logic             m_p_ready,
   input  logic             core_finished,
   input  logic [WIDTH-1:0] s_w_data,
   input  logic             s_w_valid,
   input  logic             s_w_last,
   output logic             s_w_ready,
   output logic [WIDTH-1:0] m_w_data,
   output logic             m_w_valid,
   output logic             m_w_last,
   input  logic             m_w_ready
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_TC   = 3'd1,
      STREAM_P  = 3'd2,
      WAIT_CORE = 3'd3,
      DRAIN_W   = 3'd4,
      DONE      = 3'd5
   } state_t;

   localparam logic [CNT_WIDTH-1:0] TC_LAST = CNT_WIDTH'(TC_NUM_ELEMENTS - 1);
   localparam logic [CNT_WIDTH-1:0] P_LAST  = CNT_WIDTH'(P_NUM_ELEMENTS - 1);
   localparam logic [CNT_WIDTH-1:0] W_LAST  = CNT_WIDTH'(W_NUM_ELEMENTS - 1);

   state_t               state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
   logic                 error_q, error_d;
   logic [15:0]          frame_count_q, frame_count_d;

   logic open_tc, open_p, open_w;
   logic tc_beat, p_beat, w_beat;

   // Only one path is ever open, so a single beat counter serves all three phases.
   assign open_tc = (state_q == LOAD_TC);
   assign open_p  = (state_q == STREAM_P);
   assign open_w  = (state_q == DRAIN_W);

   assign m_tc_data  = s_tc_data;
   assign m_tc_valid = s_tc_valid & open_tc;
   assign s_tc_ready = m_tc_ready & open_tc;
   assign m_tc_last  = open_tc & (cnt_q == TC_LAST);
   assign m_p_data   = s_p_data;
   assign m_p_valid  = s_p_valid & open_p;
   assign s_p_ready  = m_p_ready & open_p;
   assign m_w_data   = s_w_data;
   assign m_w_valid  = s_w_valid & open_w;
   assign s_w_ready  = m_w_ready & open_w;
   assign m_w_last   = open_w & (cnt_q == W_LAST);

   assign tc_beat = s_tc_valid & s_tc_ready;
   assign p_beat  = s_p_valid & s_p_ready;
   assign w_beat  = s_w_valid & s_w_ready;

   assign busy        = (state_q != IDLE);
   assign error       = error_q;
   assign phase       = state_q;
   assign frame_count = frame_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IDLE;
         cnt_q         <= '0;
         error_q       <= 1'b0;
         frame_count_q <= '0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         error_q       <= error_d;
         frame_count_q <= frame_count_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      error_d       = error_q;
      frame_count_d = frame_count_q;
      done          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD_TC;
               cnt_d   = '0;
               error_d = 1'b0;
            end
            if (core_finished) error_d = 1'b1;
         end
         LOAD_TC: begin
            if (core_finished) error_d = 1'b1;
            if (tc_beat) begin
               if (cnt_q == TC_LAST) begin
                  if (!s_tc_last) error_d = 1'b1;
                  cnt_d   = '0;
                  state_d = STREAM_P;
               end else begin
                  if (s_tc_last) error_d = 1'b1;
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         STREAM_P: begin
            // A finish arriving with the final pixel is legitimate, not a protocol error.
            if (p_beat && cnt_q == P_LAST) begin
               cnt_d   = '0;
               state_d = WAIT_CORE;
            end else begin
               if (core_finished) error_d = 1'b1;
               if (p_beat) cnt_d = cnt_q + CNT_WIDTH'(1);
            end
         end
         WAIT_CORE: begin
            if (core_finished) state_d = DRAIN_W;
         end
         DRAIN_W: begin
            if (w_beat) begin
               if (s_w_last != (cnt_q == W_LAST)) error_d = 1'b1;
               if (cnt_q == W_LAST) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + CNT_WIDTH'(1);
               end
            end
         end
         DONE: begin
            done          = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            state_d       = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (abort && state_q != IDLE) begin
         state_d       = IDLE;
         cnt_d         = '0;
         error_d       = error_q;
         frame_count_d = frame_count_q;
         done          = 1'b0;
      end
   end

endmodule

// File: tb/tb_lcmv_frame_sequencer.sv
// Scoreboard bench for lcmv_frame_sequencer with small element counts (TC=6, P=8, W=4).
module tb_lcmv_frame_sequencer;

   localparam int TC_N = 6;
   localparam int P_N  = 8;
   localparam int W_N  = 4;
   localparam logic [2:0] PH_IDLE = 3'd0, PH_TC = 3'd1, PH_P = 3'd2,
                          PH_WAIT = 3'd3, PH_W = 3'd4, PH_DONE = 3'd5;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, abort = 1'b0, core_finished = 1'b0;
   logic        busy, done, error;
   logic [2:0]  phase;
   logic [15:0] frame_count;
   logic [31:0] s_tc_data = '0, m_tc_data, s_p_data = '0, m_p_data, s_w_data = '0, m_w_data;
   logic        s_tc_valid = 1'b0, s_tc_last = 1'b0, s_tc_ready;
   logic        m_tc_valid, m_tc_last, m_tc_ready = 1'b1;
   logic        s_p_valid = 1'b0, s_p_ready, m_p_valid, m_p_ready = 1'b1;
   logic        s_w_valid = 1'b0, s_w_last = 1'b0, s_w_ready;
   logic        m_w_valid, m_w_last, m_w_ready = 1'b1;

   int          vec_count = 0;
   int          miss_count = 0;
   int          done_seen = 0;
   logic        bp_on = 1'b0;
   logic        gaps_on = 1'b0;
   logic [15:0] exp_fc = '0;
   logic [32:0] tc_q[$], p_q[$], w_q[$];

   lcmv_frame_sequencer #(
      .WIDTH(32), .TC_NUM_ELEMENTS(TC_N), .P_NUM_ELEMENTS(P_N),
      .W_NUM_ELEMENTS(W_N), .CNT_WIDTH(20)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done),
      .error(error), .phase(phase), .frame_count(frame_count),
      .s_tc_data(s_tc_data), .s_tc_valid(s_tc_valid), .s_tc_last(s_tc_last), .s_tc_ready(s_tc_ready),
      .m_tc_data(m_tc_data), .m_tc_valid(m_tc_valid), .m_tc_last(m_tc_last), .m_tc_ready(m_tc_ready),
      .s_p_data(s_p_data), .s_p_valid(s_p_valid), .s_p_ready(s_p_ready),
      .m_p_data(m_p_data), .m_p_valid(m_p_valid), .m_p_ready(m_p_ready),
      .core_finished(core_finished),
      .s_w_data(s_w_data), .s_w_valid(s_w_valid), .s_w_last(s_w_last), .s_w_ready(s_w_ready),
      .m_w_data(m_w_data), .m_w_valid(m_w_valid), .m_w_last(m_w_last), .m_w_ready(m_w_ready)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [32:0] act, input logic [32:0] exp);
      vec_count++;
      if (act !== exp) begin
         miss_count++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic report_missing(input string name);
      vec_count++;
      miss_count++;
      $display("[TB] FAIL %s: got no data expected a queued beat at %0t", name, $time);
   endtask

   // Downstream readiness: always ready, or randomly stalled about one cycle in four.
   initial forever begin
      @(posedge clk);
      #1;
      m_tc_ready = bp_on ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_p_ready  = bp_on ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_w_ready  = bp_on ? ($urandom_range(0, 3) != 0) : 1'b1;
   end

   // Monitor: pops the expected beat for every forwarded handshake and checks path gating.
   initial forever begin
      @(negedge clk);
      if (!rst) begin
         if (m_tc_valid && m_tc_ready) begin
            if (tc_q.size() == 0) report_missing("tcExtraBeat");
            else check_output("tcBeat", {m_tc_last, m_tc_data}, tc_q.pop_front());
         end
         if (m_p_valid && m_p_ready) begin
            if (p_q.size() == 0) report_missing("pExtraBeat");
            else check_output("pBeat", {1'b0, m_p_data}, p_q.pop_front());
         end
         if (m_w_valid && m_w_ready) begin
            if (w_q.size() == 0) report_missing("wExtraBeat");
            else check_output("wBeat", {m_w_last, m_w_data}, w_q.pop_front());
         end
         check_output("pathGate",
            {27'd0, m_tc_valid && phase != PH_TC, s_tc_ready && phase != PH_TC,
                    m_p_valid && phase != PH_P,   s_p_ready && phase != PH_P,
                    m_w_valid && phase != PH_W,   s_w_ready && phase != PH_W}, 33'd0);
         if (done) done_seen++;
      end
   end

   // Drives one beat on path 0=TC, 1=pixel, 2=W and pushes its expected forwarded form.
   task automatic apply_stimulus(input int path, input int idx, input logic last);
      logic [31:0] data;
      logic        hs;
      int          guard;
      data = 32'(32'h1000 * (path + 1) + idx);
      if (gaps_on) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      case (path)
         0: begin
            tc_q.push_back({(idx == TC_N - 1), data});
            s_tc_data = data; s_tc_last = last; s_tc_valid = 1'b1;
         end
         1: begin
            p_q.push_back({1'b0, data});
            s_p_data = data; s_p_valid = 1'b1;
         end
         default: begin
            w_q.push_back({(idx == W_N - 1), data});
            s_w_data = data; s_w_last = last; s_w_valid = 1'b1;
         end
      endcase
      hs = 1'b0;
      guard = 0;
      while (!hs && guard < 100) begin
         @(negedge clk);
         case (path)
            0:       hs = s_tc_valid && s_tc_ready;
            1:       hs = s_p_valid && s_p_ready;
            default: hs = s_w_valid && s_w_ready;
         endcase
         @(posedge clk);
         #1;
         guard++;
      end
      s_tc_valid = 1'b0; s_tc_last = 1'b0;
      s_p_valid  = 1'b0;
      s_w_valid  = 1'b0; s_w_last = 1'b0;
      if (!hs) begin
         vec_count++;
         miss_count++;
         $display("[TB] FAIL handshakeTimeout: path %0d beat %0d got no ready expected ready within 100 cycles", path, idx);
      end
   endtask

   task automatic start_frame();
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      check_output("startPhase", {30'd0, phase}, {30'd0, PH_TC});
      check_output("startErrClear", {32'd0, error}, 33'd0);
   endtask

   task automatic run_body(input int tc_bad, input int w_bad, input bit core_early,
                           input int p_beats, input int w_beats);
      if (core_early) begin
         core_finished = 1'b1;
         @(posedge clk);
         #1;
         core_finished = 1'b0;
         check_output("coreEarlyPhase", {30'd0, phase}, {30'd0, PH_TC});
         check_output("coreEarlyErr", {32'd0, error}, 33'd1);
      end
      for (int i = 0; i < TC_N; i++) apply_stimulus(0, i, (i == TC_N - 1) || (i == tc_bad));
      for (int i = 0; i < p_beats; i++) apply_stimulus(1, i, 1'b0);
      if (p_beats < P_N) return;
      repeat (3) begin @(posedge clk); #1; end
      check_output("waitCorePhase", {30'd0, phase}, {30'd0, PH_WAIT});
      core_finished = 1'b1;
      @(posedge clk);
      #1;
      core_finished = 1'b0;
      check_output("drainPhase", {30'd0, phase}, {30'd0, PH_W});
      for (int i = 0; i < w_beats; i++) apply_stimulus(2, i, (i == W_N - 1) || (i == w_bad));
   endtask

   task automatic end_frame(input logic exp_err);
      check_output("donePulse", {32'd0, done}, 33'd1);
      check_output("donePhase", {30'd0, phase}, {30'd0, PH_DONE});
      @(posedge clk);
      #1;
      exp_fc = exp_fc + 16'd1;
      check_output("doneOneCycle", {32'd0, done}, 33'd0);
      check_output("idlePhase", {30'd0, phase}, {30'd0, PH_IDLE});
      check_output("frameCount", {17'd0, frame_count}, {17'd0, exp_fc});
      check_output("frameError", {32'd0, error}, {32'd0, exp_err});
      check_output("queuesDrained", 33'(tc_q.size() + p_q.size() + w_q.size()), 33'd0);
   endtask

   initial begin
      int done_before;
      // Reset with upstream valids high: nothing may leak through.
      s_tc_valid = 1'b1; s_tc_last = 1'b1; s_w_valid = 1'b1; s_w_last = 1'b1; s_p_valid = 1'b1;
      #12;
      check_output("rstOutputs",
         {19'd0, busy, done, error, phase, s_tc_ready, m_tc_valid, m_tc_last, s_p_ready, m_p_valid,
          s_w_ready, m_w_valid, m_w_last}, 33'd0);
      check_output("rstFrameCount", {17'd0, frame_count}, 33'd0);
      s_tc_valid = 1'b0; s_tc_last = 1'b0; s_w_valid = 1'b0; s_w_last = 1'b0; s_p_valid = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] clean frame");
      start_frame();
      run_body(-1, -1, 1'b0, P_N, W_N);
      end_frame(1'b0);

      $display("[TB] backpressure and valid gaps");
      bp_on = 1'b1; gaps_on = 1'b1;
      start_frame();
      run_body(-1, -1, 1'b0, P_N, W_N);
      end_frame(1'b0);
      bp_on = 1'b0; gaps_on = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] early TC last on beat 3");
      start_frame();
      run_body(2, -1, 1'b0, P_N, W_N);
      end_frame(1'b1);

      $display("[TB] abort after 5 pixels");
      done_before = done_seen;
      start_frame();
      run_body(-1, -1, 1'b0, 5, 0);
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      check_output("abortPhase", {30'd0, phase}, {30'd0, PH_IDLE});
      check_output("abortReady", {31'd0, busy, s_p_ready}, 33'd0);
      check_output("abortFrameCount", {17'd0, frame_count}, {17'd0, exp_fc});
      @(posedge clk);
      #1;
      check_output("abortNoDone", 33'(done_seen - done_before), 33'd0);

      $display("[TB] clean frame after abort");
      start_frame();
      run_body(-1, -1, 1'b0, P_N, W_N);
      end_frame(1'b0);

      $display("[TB] core_finished during LOAD_TC");
      start_frame();
      run_body(-1, -1, 1'b1, P_N, W_N);
      end_frame(1'b1);

      $display("[TB] W last on beat 2");
      start_frame();
      run_body(-1, 1, 1'b0, P_N, W_N);
      end_frame(1'b1);

      $display("[TB] async reset mid DRAIN_W");
      start_frame();
      run_body(-1, -1, 1'b0, P_N, 2);
      #3;
      rst = 1'b1;
      #1;
      check_output("midRstOutputs",
         {26'd0, busy, done, error, phase, s_w_ready}, 33'd0);
      check_output("midRstFrameCount", {17'd0, frame_count}, 33'd0);
      exp_fc = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;

      $display("[TB] back-to-back frames with start held");
      start = 1'b1;
      @(posedge clk);
      #1;
      check_output("heldStartPhase", {30'd0, phase}, {30'd0, PH_TC});
      run_body(-1, -1, 1'b0, P_N, W_N);
      check_output("heldDonePulse", {32'd0, done}, 33'd1);
      @(posedge clk);
      #1;
      check_output("heldIdlePhase", {30'd0, phase}, {30'd0, PH_IDLE});
      check_output("heldFrameCount1", {17'd0, frame_count}, 33'd1);
      @(posedge clk);
      #1;
      check_output("heldRestart", {30'd0, phase}, {30'd0, PH_TC});
      start = 1'b0;
      exp_fc = 16'd1;
      run_body(-1, -1, 1'b0, P_N, W_N);
      end_frame(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no completion expected completion within 200000 time units");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
